// File: rtl/game_flow_controller_if.sv
// Handshake bundle between the game sequencer and the playfield logic.
// The controller takes the slave modport; the playfield/testbench side takes master.
interface game_flow_controller_if #(
    parameter int NUM_GOODIES = 9
);
    logic                   start_btn;
    logic                   pause_btn;
    logic                   obstacle_hit;
    logic [NUM_GOODIES-1:0] collected;
    logic [3:0]             score;

    logic                   game_start;
    logic                   play;
    logic                   game_over;
    logic                   win;
    logic [1:0]             lives;
    logic [6:0]             time_left;
    logic [3:0]             final_score;
    logic [2:0]             state;

    modport master (
        output start_btn, pause_btn, obstacle_hit, collected, score,
        input  game_start, play, game_over, win, lives, time_left, final_score, state
    );

    modport slave (
        input  start_btn, pause_btn, obstacle_hit, collected, score,
        output game_start, play, game_over, win, lives, time_left, final_score, state
    );
endinterface

// File: rtl/game_flow_controller.sv
// Game sequencer: start/clear/arm/play flow, lives, seconds timer, hit invulnerability, score latch.
// Optional pause support is compiled in when the PAUSE_EN macro is defined.
module game_flow_controller #(
    parameter int NUM_GOODIES   = 9,
    parameter int LIVES         = 3,
    parameter int TIME_LIMIT    = 60,
    parameter int TICK_DIV      = 100_000_000,
    parameter int INVULN_CYCLES = 50_000_000
) (
    input logic                   clk,
    input logic                   rst_n,
    game_flow_controller_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;
    localparam logic [NUM_GOODIES-1:0] ALL_GOODIES = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ARM    = 3'd2,
        S_PLAY   = 3'd3,
        S_PAUSED = 3'd4,
        S_WIN    = 3'd5,
        S_LOSE   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic          start_q, pause_q, hit_q;
    logic [1:0]    lives_q, lives_d;
    logic [6:0]    time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] invuln_q, invuln_d;
    logic [3:0]    fscore_q, fscore_d;

    logic start_edge, pause_edge, hit_edge, all_collected, hit_counted;

    assign start_edge    = bus.start_btn & ~start_q;
    assign pause_edge    = bus.pause_btn & ~pause_q;
    assign hit_edge      = bus.obstacle_hit & ~hit_q;
    assign all_collected = (bus.collected == ALL_GOODIES);

`ifndef PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause_edge;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            pause_q  <= 1'b0;
            hit_q    <= 1'b0;
            lives_q  <= 2'(LIVES);
            time_q   <= 7'(TIME_LIMIT);
            presc_q  <= '0;
            invuln_q <= '0;
            fscore_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus.start_btn;
            pause_q  <= bus.pause_btn;
            hit_q    <= bus.obstacle_hit;
            lives_q  <= lives_d;
            time_q   <= time_d;
            presc_q  <= presc_d;
            invuln_q <= invuln_d;
            fscore_q <= fscore_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        time_d      = time_q;
        presc_d     = presc_q;
        invuln_d    = invuln_q;
        fscore_d    = fscore_q;
        hit_counted = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                lives_d  = 2'(LIVES);
                time_d   = 7'(TIME_LIMIT);
                presc_d  = '0;
                invuln_d = '0;
                state_d  = S_ARM;
            end
            S_ARM: begin
                if (bus.collected == '0) state_d = S_PLAY;
            end
            S_PLAY: begin
                // A winning cycle swallows any simultaneous hit.
                hit_counted = hit_edge && (invuln_q == '0) && !all_collected && (lives_q != 2'd0);

                if (presc_q == PW'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    if (time_q != 7'd0) time_d = time_q - 7'd1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end

                if (hit_counted) begin
                    lives_d  = lives_q - 2'd1;
                    invuln_d = IW'(INVULN_CYCLES);
                end else if (invuln_q != '0) begin
                    invuln_d = invuln_q - IW'(1);
                end

                if (start_edge) begin
                    state_d = S_CLEAR;
                end else if (all_collected) begin
                    state_d  = S_WIN;
                    fscore_d = bus.score;
                end else if ((hit_counted && lives_q == 2'd1) || time_q == 7'd0) begin
                    state_d  = S_LOSE;
                    fscore_d = bus.score;
                end
`ifdef PAUSE_EN
                else if (pause_edge) begin
                    state_d = S_PAUSED;
                end
`endif
            end
            S_PAUSED: begin
`ifdef PAUSE_EN
                if (start_edge)      state_d = S_CLEAR;
                else if (pause_edge) state_d = S_PLAY;
`else
                state_d = S_IDLE;
`endif
            end
            S_WIN, S_LOSE: begin
                if (start_edge) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.game_start  = (state_q == S_CLEAR);
    assign bus.play        = (state_q == S_PLAY);
    assign bus.game_over   = (state_q == S_WIN) || (state_q == S_LOSE);
    assign bus.win         = (state_q == S_WIN);
    assign bus.lives       = lives_q;
    assign bus.time_left   = time_q;
    assign bus.final_score = fscore_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: vector table, directed corner sequences, randomized run vs. model.
module tb_game_flow_controller;
    localparam int NG  = 9;
    localparam int LV  = 3;
    localparam int TL  = 5;
    localparam int TD  = 4;
    localparam int INV = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    game_flow_controller_if #(.NUM_GOODIES(NG)) bus ();

    game_flow_controller #(
        .NUM_GOODIES  (NG),
        .LIVES        (LV),
        .TIME_LIMIT   (TL),
        .TICK_DIV     (TD),
        .INVULN_CYCLES(INV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: game progress is tracked as elapsed PLAY cycles; the clock
    // and invulnerability are derived from that count instead of explicit counters.
    typedef struct packed {
        int ms;
        int lives;
        int pc;
        int last;
        int fs;
        bit pst;
        bit ppa;
        bit phi;
    } mdl_t;

    mdl_t m;

    function automatic int tl_of(int pc);
        int t;
        t = TL - pc / TD;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.ms = 0; r.lives = LV; r.pc = 0; r.last = -100; r.fs = 0;
        r.pst = 1'b0; r.ppa = 1'b0; r.phi = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t c, bit st, bit pa, bit hi, logic [NG-1:0] col, logic [3:0] sc);
        mdl_t n;
        bit se, he, allc, cnt;
`ifdef PAUSE_EN
        bit pe;
        pe = pa & ~c.ppa;
`endif
        n    = c;
        se   = st & ~c.pst;
        he   = hi & ~c.phi;
        allc = (col == {NG{1'b1}});
        case (c.ms)
            0: if (se) n.ms = 1;
            1: begin n.lives = LV; n.pc = 0; n.last = -100; n.ms = 2; end
            2: if (col == '0) n.ms = 2 + 1;
            3: begin
                cnt  = he && !allc && (c.pc >= c.last + 1 + INV);
                n.pc = c.pc + 1;
                if (cnt) begin n.lives = c.lives - 1; n.last = c.pc; end
                if (se) n.ms = 1;
                else if (allc) begin n.ms = 5; n.fs = sc; end
                else if ((cnt && n.lives == 0) || tl_of(c.pc) == 0) begin n.ms = 6; n.fs = sc; end
`ifdef PAUSE_EN
                else if (pe) n.ms = 4;
`endif
            end
            4: begin
`ifdef PAUSE_EN
                if (se) n.ms = 1;
                else if (pe) n.ms = 3;
`endif
            end
            default: if (se) n.ms = 1;
        endcase
        n.pst = st; n.ppa = pa; n.phi = hi;
        return n;
    endfunction

    function automatic logic [19:0] mdl_out(mdl_t c);
        return {c.ms == 1, c.ms == 3, (c.ms == 5) || (c.ms == 6), c.ms == 5,
                2'(c.lives), 7'(tl_of(c.pc)), 4'(c.fs), 3'(c.ms)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_reset();
        else        m <= mdl_step(m, bus.start_btn, bus.pause_btn, bus.obstacle_hit, bus.collected, bus.score);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_in(bit st, bit pa, bit hi, logic [NG-1:0] col, logic [3:0] sc);
        bus.start_btn    = st;
        bus.pause_btn    = pa;
        bus.obstacle_hit = hi;
        bus.collected    = col;
        bus.score        = sc;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, '0, '0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic start_game();
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        step();
        step();
        chk("start_play", int'(bus.play), 1);
    endtask

    typedef struct {
        bit          st;
        logic [NG-1:0] col;
        logic [3:0]  sc;
        int gs, pl, win, go, lives, tleft, fs, state;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{0, 9'h000, 4'd0, 0, 0, 0, 0, 3, 5, 0, 0};
        tbl[1] = '{1, 9'h000, 4'd0, 1, 0, 0, 0, 3, 5, 0, 1};
        tbl[2] = '{1, 9'h000, 4'd0, 0, 0, 0, 0, 3, 5, 0, 2};
        tbl[3] = '{1, 9'h000, 4'd0, 0, 1, 0, 0, 3, 5, 0, 3};
        tbl[4] = '{1, 9'h1FF, 4'd9, 0, 0, 1, 1, 3, 5, 9, 5};
        tbl[5] = '{0, 9'h000, 4'd0, 0, 0, 1, 1, 3, 5, 9, 5};
        tbl[6] = '{1, 9'h000, 4'd0, 1, 0, 0, 0, 3, 5, 9, 1};
        tbl[7] = '{0, 9'h1FF, 4'd0, 0, 0, 0, 0, 3, 5, 9, 2};
        tbl[8] = '{0, 9'h1FF, 4'd0, 0, 0, 0, 0, 3, 5, 9, 2};
        tbl[9] = '{0, 9'h000, 4'd0, 0, 1, 0, 0, 3, 5, 9, 3};

        do_reset();
        chk("reset_state", int'(bus.state), 0);
        chk("reset_go", int'(bus.game_over), 0);
        chk("reset_fs", int'(bus.final_score), 0);

        // start latency, win latch, restart from WIN, ARM waits for cleared goodies
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].st, 0, 0, tbl[i].col, tbl[i].sc);
            step();
            chk($sformatf("tbl%0d_gs", i), int'(bus.game_start), tbl[i].gs);
            chk($sformatf("tbl%0d_play", i), int'(bus.play), tbl[i].pl);
            chk($sformatf("tbl%0d_win", i), int'(bus.win), tbl[i].win);
            chk($sformatf("tbl%0d_go", i), int'(bus.game_over), tbl[i].go);
            chk($sformatf("tbl%0d_lives", i), int'(bus.lives), tbl[i].lives);
            chk($sformatf("tbl%0d_time", i), int'(bus.time_left), tbl[i].tleft);
            chk($sformatf("tbl%0d_fs", i), int'(bus.final_score), tbl[i].fs);
            chk($sformatf("tbl%0d_state", i), int'(bus.state), tbl[i].state);
        end

        // hits at PLAY+0,+3,+10,+20
        do_reset();
        start_game();
        for (int i = 0; i <= 20; i++) begin
            bus.obstacle_hit = (i == 0) || (i == 3) || (i == 10) || (i == 20);
            step();
            if (i == 0)  chk("hit0_lives", int'(bus.lives), 2);
            if (i == 3)  chk("hit3_ignored", int'(bus.lives), 2);
            if (i == 10) chk("hit10_lives", int'(bus.lives), 1);
        end
        bus.obstacle_hit = 1'b0;
        chk("hit20_lives", int'(bus.lives), 0);
        chk("hit20_state", int'(bus.state), 6);
        chk("hit20_win", int'(bus.win), 0);
        chk("hit20_go", int'(bus.game_over), 1);

        // timeout
        do_reset();
        start_game();
        for (int i = 0; i <= 20; i++) begin
            step();
            if ((i + 1) % TD == 0) chk($sformatf("time_at%0d", i), int'(bus.time_left), TL - (i + 1) / TD);
            if (i == 19) chk("time_still_play", int'(bus.state), 3);
        end
        chk("timeout_state", int'(bus.state), 6);
        chk("timeout_lives", int'(bus.lives), 3);
        chk("timeout_time", int'(bus.time_left), 0);

        // last life hit coincides with full collection
        do_reset();
        start_game();
        for (int i = 0; i <= 18; i++) begin
            bus.obstacle_hit = (i == 0) || (i == 9) || (i == 18);
            bus.collected    = (i == 18) ? 9'h1FF : 9'h000;
            bus.score        = 4'd7;
            step();
            if (i == 9) chk("win_hit_prelives", int'(bus.lives), 1);
        end
        set_in(0, 0, 0, '0, '0);
        chk("win_hit_state", int'(bus.state), 5);
        chk("win_hit_lives", int'(bus.lives), 1);
        chk("win_hit_fs", int'(bus.final_score), 7);

        // level held across invulnerability window end counts once
        do_reset();
        start_game();
        bus.obstacle_hit = 1'b1;
        repeat (15) step();
        chk("held_hit_lives", int'(bus.lives), 2);
        bus.obstacle_hit = 1'b0;
        step();

`ifdef PAUSE_EN
        do_reset();
        start_game();
        repeat (5) step();
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
        chk("pause_state", int'(bus.state), 4);
        repeat (30) step();
        chk("pause_time", int'(bus.time_left), 4);
        chk("pause_play", int'(bus.play), 0);
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
        chk("resume_state", int'(bus.state), 3);
        step();
        step();
        chk("resume_time", int'(bus.time_left), 3);
`else
        bus.pause_btn = 1'b1;
        step();
        bus.pause_btn = 1'b0;
        chk("pause_ignored", int'(bus.state), 3);
`endif

        // asynchronous reset mid-PLAY
        do_reset();
        start_game();
        bus.obstacle_hit = 1'b1;
        step();
        bus.obstacle_hit = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_play", int'(bus.play), 0);
        chk("arst_lives", int'(bus.lives), 3);
        chk("arst_time", int'(bus.time_left), 5);
        #1;
        rst_n = 1'b1;
        step();

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [19:0] act, exp;
            r = int'($urandom_range(0, 15));
            set_in($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                   (r == 0) ? 9'h1FF : (r == 1) ? 9'($urandom) : 9'h000, 4'($urandom));
            step();
            act = {bus.game_start, bus.play, bus.game_over, bus.win, bus.lives,
                   bus.time_left, bus.final_score, bus.state};
            exp = mdl_out(m);
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL rand_cycle%0d actual=%h required=%h", i, act, exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
